// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: runs one AES-128 block through an external combinational round datapath
// Ports: clk/reset (async, active-low); in_valid/in_ready/in_block/in_key accept plaintext and key;
//   key_out/key_round/key_req/key_ack/round_key talk to the key schedule; rnd_state/rnd_first/
//   rnd_last/rnd_result drive and collect the round datapath; out_valid/out_ready/out_block return
//   ciphertext. Define AES_SEQ_ABORT_EN to add an abort input that drops RUN/DONE back to IDLE.
module aes128_round_sequencer #(
  parameter int NR = 10,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef AES_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  input  logic [127:0]       in_key,
  output logic [127:0]       key_out,
  output logic [ROUND_W-1:0] key_round,
  output logic               key_req,
  input  logic               key_ack,
  input  logic [127:0]       round_key,
  output logic [127:0]       rnd_state,
  output logic               rnd_first,
  output logic               rnd_last,
  input  logic [127:0]       rnd_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NR);
  fsm_t fsm, nxt;
  logic [127:0] state_q, key_q;
  logic [ROUND_W-1:0] round_q, rnd_nxt;
  logic accept, step, handoff, abort_hit, unused;
  // round_key is consumed only by the datapath; it is listed here for a complete round interface
  assign unused = ^round_key;
  // handshakes qualify on registered flags, so in_ready/key_req/out_valid never depend on inputs
  assign accept = in_valid && in_ready;
  assign step = key_req && key_ack;
  assign handoff = out_valid && out_ready;
`ifdef AES_SEQ_ABORT_EN
  assign abort_hit = abort && fsm != IDLE;
`else
  assign abort_hit = 1'b0;
`endif
  assign key_out = key_q;
  assign key_round = round_q;
  assign rnd_state = state_q;
  assign out_block = state_q;
  always_comb begin
    nxt = fsm;
    rnd_nxt = round_q;
    if (abort_hit) begin
      nxt = IDLE;
      rnd_nxt = '0;
    end else if (accept) begin
      nxt = RUN;
      rnd_nxt = '0;
    end else if (step) begin
      nxt = round_q == LAST ? DONE : RUN;
      rnd_nxt = round_q == LAST ? round_q : round_q + ROUND_W'(1);
    end else if (handoff) begin
      nxt = IDLE;
    end
  end
  // status outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm <= IDLE;
      state_q <= '0;
      key_q <= '0;
      round_q <= '0;
      in_ready <= 1'b0;
      key_req <= 1'b0;
      out_valid <= 1'b0;
      rnd_first <= 1'b0;
      rnd_last <= 1'b0;
    end else begin
      fsm <= nxt;
      round_q <= rnd_nxt;
      state_q <= abort_hit ? '0 : accept ? in_block : step ? rnd_result : state_q;
      key_q <= accept ? in_key : key_q;
      in_ready <= nxt == IDLE;
      key_req <= nxt == RUN;
      out_valid <= nxt == DONE;
      rnd_first <= nxt == RUN && rnd_nxt == '0;
      rnd_last <= nxt == RUN && rnd_nxt == LAST;
    end
  end
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// tb_aes128_round_sequencer: checks the sequencer against known AES-128 ciphertexts using a behavioural round datapath and key schedule
module tb_aes128_round_sequencer;
  localparam int NR = 10;
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid, in_ready, key_req, key_ack, rnd_first, rnd_last, out_valid, out_ready;
  logic [127:0] in_block, in_key, key_out, round_key, rnd_state, rnd_result, out_block;
  logic [3:0] key_round;
`ifdef AES_SEQ_ABORT_EN
  logic abort;
`endif
  int cmp = 0;
  int bad = 0;
  bit stall_mode = 1'b0;
  int stall_left = 0;
  int viol = 0;
  bit held = 1'b0;
  logic [3:0] held_round;
  int seq[$];
  vec_t vecs[3];

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, p, e, b;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_sched(input logic [127:0] key, input logic [3:0] r);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    int ri;
    if (r > 4'd10) return '0;
    ri = int'(r);
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*ri], w[4*ri+1], w[4*ri+2], w[4*ri+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic first, input logic last);
    logic [7:0] b[16];
    logic [7:0] t[16];
    logic [127:0] o;
    if (first) return s ^ k;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last)
      for (int c = 0; c < 4; c++) begin
        b[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
        b[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
        b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
        b[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        for (int r = 0; r < 4; r++) t[4*c+r] = b[4*c+r];
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  assign round_key = key_sched(key_out, key_round);
  assign rnd_result = aes_round(rnd_state, round_key, rnd_first, rnd_last);

  aes128_round_sequencer #(.NR(NR), .ROUND_W(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef AES_SEQ_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_block(in_block),
    .in_key(in_key),
    .key_out(key_out),
    .key_round(key_round),
    .key_req(key_req),
    .key_ack(key_ack),
    .round_key(round_key),
    .rnd_state(rnd_state),
    .rnd_first(rnd_first),
    .rnd_last(rnd_last),
    .rnd_result(rnd_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block)
  );

  always @(negedge clk)
    if (!stall_mode) key_ack = 1'b1;
    else if (key_req && stall_left == 0) begin
      key_ack = 1'b1;
      stall_left = $urandom_range(0, 5);
    end else begin
      key_ack = 1'b0;
      if (key_req) stall_left--;
    end

  always @(posedge clk) begin
    if (held && key_req && key_round != held_round) viol++;
    held = key_req && !key_ack;
    held_round = key_round;
    if (key_req && key_ack) seq.push_back(int'(key_round));
  end

  function automatic bit seq_ok();
    if (seq.size() != NR + 1) return 1'b0;
    foreach (seq[i]) if (seq[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic start(input logic [127:0] k, input logic [127:0] p, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    in_key = k;
    in_block = p;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_ready", in_ready, 1'b1);
    seq.delete();
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic finish_block(output logic [127:0] ct, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
    @(negedge clk);
    ct = out_block;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] ct, ct0;
    int lat, n;
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_block = '0;
    in_key = '0;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_key_req", key_req, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_block", out_block, '0);
    chk("rst_key_out", key_out, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      start(vecs[i].key, vecs[i].pt, 1'b0);
      finish_block(ct, lat);
      chk($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(11));
      chk1($sformatf("vec%0d_key_seq", i), seq_ok(), 1'b1);
      chk1($sformatf("vec%0d_done_in_ready", i), in_ready, 1'b0);
      handshake();
      chk1($sformatf("vec%0d_idle_in_ready", i), in_ready, 1'b1);
      chk1($sformatf("vec%0d_idle_out_valid", i), out_valid, 1'b0);
    end

    stall_mode = 1'b1;
    viol = 0;
    start(vecs[0].key, vecs[0].pt, 1'b0);
    finish_block(ct, lat);
    chk("stall_ct", ct, vecs[0].ct);
    chk1("stall_key_seq", seq_ok(), 1'b1);
    chk("stall_key_stable", 128'(viol), 128'(0));
    handshake();
    stall_mode = 1'b0;

    start(vecs[0].key, vecs[0].pt, 1'b0);
    finish_block(ct0, lat);
    in_key = vecs[1].key;
    in_block = vecs[1].pt;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_block", out_block, vecs[0].ct);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    handshake();
    chk1("bp_release_out_valid", out_valid, 1'b0);
    chk1("bp_release_in_ready", in_ready, 1'b1);
    chk1("bp_release_key_req", key_req, 1'b0);

    start(vecs[0].key, vecs[0].pt, 1'b0);
    n = 0;
    while (key_round != 4'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_round", 128'(key_round), 128'(5));
    reset = 1'b0;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk1("midrst_key_req", key_req, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_state", rnd_state, '0);
    @(negedge clk);
    reset = 1'b1;
    start(vecs[0].key, vecs[0].pt, 1'b0);
    finish_block(ct, lat);
    chk("midrst_rerun_ct", ct, vecs[0].ct);
    handshake();

    start(vecs[0].key, vecs[0].pt, 1'b1);
    in_key = vecs[1].key;
    in_block = vecs[1].pt;
    finish_block(ct, lat);
    chk("b2b_first_ct", ct, vecs[0].ct);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk1("b2b_gap_in_ready", in_ready, 1'b1);
    chk1("b2b_gap_key_req", key_req, 1'b0);
    seq.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk1("b2b_second_accept", key_req, 1'b1);
    finish_block(ct, lat);
    chk("b2b_second_ct", ct, vecs[1].ct);
    chk("b2b_second_latency", 128'(lat), 128'(11));
    handshake();

`ifdef AES_SEQ_ABORT_EN
    start(vecs[0].key, vecs[0].pt, 1'b0);
    n = 0;
    while (key_round != 4'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_at_round", 128'(key_round), 128'(3));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_key_req", key_req, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk("abort_state", rnd_state, '0);
    chk("abort_round", 128'(key_round), 128'(0));
    start(vecs[0].key, vecs[0].pt, 1'b0);
    finish_block(ct, lat);
    chk("abort_rerun_ct", ct, vecs[0].ct);
    handshake();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk1("idle_abort_in_ready", in_ready, 1'b1);
    chk1("idle_abort_key_req", key_req, 1'b0);
    chk("idle_abort_key_out", key_out, vecs[0].key);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
